// File: rtl/geq_serial_pkg.sv
// Shared definitions for the bit-serial signed >= comparator.
package geq_serial_pkg;

    localparam int unsigned GEQ_WIDTH = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/geq_step.sv
// One-bit LSB-first update of the running greater-than / equal flags.
module geq_step (
    input  logic a,
    input  logic b,
    input  logic gt_in,
    input  logic eq_in,
    input  logic is_sign,
    output logic gt_out,
    output logic eq_out
);

    logic same;

    assign same = a ~^ b;

    // On the sign bit a set A bit means negative, so the winner flips.
    assign gt_out = (is_sign ? (~a & b) : (a & ~b)) | (same & gt_in);
    assign eq_out = eq_in & same;

endmodule

// File: rtl/geq_serial.sv
// Bit-serial two's-complement A>=B / A==B comparator, operands streamed LSB first.
module geq_serial
    import geq_serial_pkg::*;
#(
    parameter int unsigned WIDTH = GEQ_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             bit_valid,
    input  logic             a_bit,
    input  logic             b_bit,
    output logic             bit_ready,
    output logic             busy,
    output logic             done,
    output logic             geq,
    output logic             eq,
    output logic [WIDTH-1:0] a_word,
    output logic [WIDTH-1:0] b_word
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               gt_run_q, gt_run_d;
    logic               eq_run_q, eq_run_d;
    logic               geq_q, geq_d;
    logic               eq_q, eq_d;
    logic [WIDTH-1:0]   a_word_q, a_word_d;
    logic [WIDTH-1:0]   b_word_q, b_word_d;
    logic               bit_ready_q, busy_q, done_q;

    logic               is_sign;
    logic               gt_step, eq_step;

    assign is_sign = (cnt_q == CNT_W'(WIDTH - 1));

    geq_step u_step (
        .a       (a_bit),
        .b       (b_bit),
        .gt_in   (gt_run_q),
        .eq_in   (eq_run_q),
        .is_sign (is_sign),
        .gt_out  (gt_step),
        .eq_out  (eq_step)
    );

    // Next-state, counter, running flags and operand assembly.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        gt_run_d = gt_run_q;
        eq_run_d = eq_run_q;
        geq_d    = geq_q;
        eq_d     = eq_q;
        a_word_d = a_word_q;
        b_word_d = b_word_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = SHIFT;
                    cnt_d    = '0;
                    gt_run_d = 1'b0;
                    eq_run_d = 1'b1;
                    geq_d    = 1'b0;
                    eq_d     = 1'b0;
                    a_word_d = '0;
                    b_word_d = '0;
                end
            end
            SHIFT: begin
                if (bit_valid) begin
                    a_word_d[cnt_q] = a_bit;
                    b_word_d[cnt_q] = b_bit;
                    gt_run_d        = gt_step;
                    eq_run_d        = eq_step;
                    if (is_sign) begin
                        state_d = DONE;
                        geq_d   = gt_step | eq_step;
                        eq_d    = eq_step;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs; handshake/status flags decode the next state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            gt_run_q    <= 1'b0;
            eq_run_q    <= 1'b0;
            geq_q       <= 1'b0;
            eq_q        <= 1'b0;
            a_word_q    <= '0;
            b_word_q    <= '0;
            bit_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            gt_run_q    <= gt_run_d;
            eq_run_q    <= eq_run_d;
            geq_q       <= geq_d;
            eq_q        <= eq_d;
            a_word_q    <= a_word_d;
            b_word_q    <= b_word_d;
            bit_ready_q <= (state_d == SHIFT);
            busy_q      <= (state_d == SHIFT) || (state_d == DONE);
            done_q      <= (state_d == DONE);
        end
    end

    assign bit_ready = bit_ready_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign geq       = geq_q;
    assign eq        = eq_q;
    assign a_word    = a_word_q;
    assign b_word    = b_word_q;

endmodule
